branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of each statistics counter.
REQ-003 The block SHALL have port clk  input  1  the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port en  input  1  global enable, where 0 blocks acceptance of new operations.
REQ-006 The block SHALL have port in_valid  input  1  request to resolve one branch.
REQ-007 The block SHALL have port in_ready  output  1  the block can accept an operation this cycle.
REQ-008 The block SHALL have port a  input  WIDTH  first operand (rs).
REQ-009 The block SHALL have port b  input  WIDTH  second operand (rt).
REQ-010 The block SHALL have port cond  input  3  condition code, per REQ-017.
REQ-011 The block SHALL have port flush  input  1  discard the held result and block acceptance this cycle.
REQ-012 The block SHALL have port clear_stats  input  1  zero both statistics counters.
REQ-013 The block SHALL have port out_valid  output  1  taken/zero hold a valid result.
REQ-014 The block SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-015 The block SHALL have ports taken  output  1 (branch condition true) and zero  output  1 (a==b, for all cond).
REQ-016 The block SHALL have ports branch_count  output  CNT_W (operations accepted) and taken_count  output  CNT_W (accepted operations with taken=1).

Function
REQ-017 The cond encoding SHALL be 0 EQ a==b, 1 NE a!=b, 2 LEZ signed a<=0, 3 GTZ signed a>0, 4 LTZ signed a<0, 5 GEZ signed a>=0, 6 LT signed a<b, 7 LTU unsigned a<b.
REQ-018 Comparisons SHALL use the full WIDTH with no truncation, where signed means two's complement with MSB as sign, and b SHALL be ignored for codes 2-5.
REQ-019 in_ready SHALL equal en & !flush & (!out_valid | out_ready), combinationally.
REQ-020 An operation SHALL be accepted in any cycle where in_valid & in_ready is 1.
REQ-021 On acceptance, taken and zero SHALL be registered and out_valid set to 1 on the next edge, giving a latency of exactly 1 cycle.
REQ-022 If out_valid & out_ready is 1 and no acceptance occurs, out_valid SHALL clear on the next edge.
REQ-023 A simultaneous output handoff and new acceptance SHALL load the new result with out_valid staying 1, so back-to-back throughput is 1 operation per cycle.
REQ-024 While out_valid=1 and out_ready=0, taken and zero SHALL hold stable.
REQ-025 flush=1 SHALL clear out_valid on the next edge, and no acceptance SHALL occur in that cycle.
REQ-026 taken and zero SHALL retain their last values when out_valid=0.
REQ-027 branch_count SHALL increment by 1 per acceptance and saturate at 2^CNT_W-1.
REQ-028 taken_count SHALL increment by 1 per acceptance with taken result 1 and saturate at 2^CNT_W-1.
REQ-029 clear_stats=1 SHALL set both counters to 0 on the next edge, taking priority over any same-cycle increment, and an acceptance in that cycle SHALL NOT be counted.
REQ-030 Counters SHALL NOT be affected by flush.

Reset
REQ-031 With rst=1 at an edge, the block SHALL set out_valid=0, taken=0, zero=0, branch_count=0 and taken_count=0.
REQ-032 rst SHALL override flush, clear_stats and acceptance, and an operation presented during reset SHALL be lost.
REQ-033 in_ready SHALL follow REQ-019 during reset, which yields en & !flush because out_valid is 0.

Structure
REQ-034 Cond code constants (COND_EQ..COND_LTU) and the cond width SHALL live in shared package branch_pkg, for reuse by the decode stage.
REQ-035 Condition evaluation SHALL be one combinational sub-module, branch_cond_eval (inputs a, b, cond; outputs taken, zero), parametrised by WIDTH.
REQ-036 The handshake register and counters SHALL reside in branch_resolve_unit.

Verification
REQ-037 The bench SHALL apply reset, then a=5, b=5, cond=EQ, in_valid=1, out_ready=1, requiring next cycle out_valid=1, taken=1, zero=1, branch_count=1, taken_count=1.
REQ-038 The bench SHALL apply a=32'hFFFF_FFFF, b=1 with cond=LT then cond=LTU back-to-back, requiring taken=1 then taken=0, out_valid continuously 1, and branch_count=2.
REQ-039 The bench SHALL hold out_ready=0 with a result pending, then present a=0, cond=LEZ, requiring in_ready=0, held outputs stable, and acceptance on the cycle after out_ready=1.
REQ-040 The bench SHALL assert flush with out_valid=1 and in_valid=1, requiring out_valid=0 next cycle, no acceptance, and branch_count unchanged.
REQ-041 The bench SHALL run with CNT_W=4 for 20 accepted taken operations, requiring both counters at 15; clear_stats together with an acceptance SHALL then give both counters 0.
REQ-042 The bench SHALL assert rst mid-stream with in_valid=1, requiring out_valid=0 and counters 0 after the edge, and the operation SHALL NOT be reported.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch condition encoding, reused by the decode stage and the resolve unit.
package branch_pkg;

    localparam int unsigned COND_W = 3;

    typedef enum logic [COND_W-1:0] {
        COND_EQ  = 3'd0,
        COND_NE  = 3'd1,
        COND_LEZ = 3'd2,
        COND_GTZ = 3'd3,
        COND_LTZ = 3'd4,
        COND_GEZ = 3'd5,
        COND_LT  = 3'd6,
        COND_LTU = 3'd7
    } cond_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation over the full operand width.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [COND_W-1:0] cond,
    output logic              taken,
    output logic              zero
);

    logic a_neg;
    logic a_is_zero;
    logic lt_signed;
    logic lt_unsigned;

    // Single-operand codes only look at the sign bit and a zero test of a.
    always_comb begin
        a_neg       = a[WIDTH-1];
        a_is_zero   = (a == '0);
        lt_signed   = ($signed(a) < $signed(b));
        lt_unsigned = (a < b);
        zero        = (a == b);
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ:  taken = zero;
            COND_NE:  taken = !zero;
            COND_LEZ: taken = a_neg | a_is_zero;
            COND_GTZ: taken = !a_neg & !a_is_zero;
            COND_LTZ: taken = a_neg;
            COND_GEZ: taken = !a_neg;
            COND_LT:  taken = lt_signed;
            COND_LTU: taken = lt_unsigned;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: one-deep result register with valid/ready handshake and
// saturating statistics counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [COND_W-1:0] cond,
    input  logic              flush,
    input  logic              clear_stats,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              taken,
    output logic              zero,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic eval_taken;
    logic eval_zero;
    logic accept;

    branch_cond_eval #(
        .WIDTH (WIDTH)
    ) u_eval (
        .a     (a),
        .b     (b),
        .cond  (cond),
        .taken (eval_taken),
        .zero  (eval_zero)
    );

    always_comb begin
        in_ready = en & !flush & (!out_valid | out_ready);
        accept   = in_valid & in_ready;
    end

    // accept already excludes flush, so a load always wins over a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            taken     <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            taken     <= eval_taken;
            zero      <= eval_zero;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (accept) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_ONE;
            end
            if (eval_taken && (taken_count != '1)) begin
                taken_count <= taken_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle-level reference model.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst, en, in_valid, in_ready, flush, clear_stats;
    logic              out_valid, out_ready, taken, zero;
    logic [WIDTH-1:0]  a, b;
    logic [COND_W-1:0] cond;
    logic [CNT_W-1:0]  branch_count, taken_count;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit m_on = 0;
    bit m_valid, m_taken, m_zero;
    int m_bc, m_tc;

    branch_resolve_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .cond         (cond),
        .flush        (flush),
        .clear_stats  (clear_stats),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .taken        (taken),
        .zero         (zero),
        .branch_count (branch_count),
        .taken_count  (taken_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Branch outcome from plain signed/unsigned integer arithmetic.
    function automatic bit ref_taken(input logic [31:0] x, input logic [31:0] y, input int c);
        longint sx, sy, ux, uy;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[31] ? ux - 64'sh1_0000_0000 : ux;
        sy = y[31] ? uy - 64'sh1_0000_0000 : uy;
        case (c)
            0: return ux == uy;
            1: return ux != uy;
            2: return sx <= 0;
            3: return sx > 0;
            4: return sx < 0;
            5: return sx >= 0;
            6: return sx < sy;
            default: return ux < uy;
        endcase
    endfunction

    always @(posedge clk) begin
        bit rdy, acc, t;
        if (rst) begin
            m_on = 1; m_valid = 0; m_taken = 0; m_zero = 0; m_bc = 0; m_tc = 0;
        end else if (m_on) begin
            rdy = en && !flush && (!m_valid || out_ready);
            acc = in_valid && rdy;
            t   = ref_taken(a, b, int'(cond));
            if (acc) begin
                m_valid = 1; m_taken = t; m_zero = (a == b);
            end else if (flush || out_ready) begin
                m_valid = 0;
            end
            if (clear_stats) begin
                m_bc = 0; m_tc = 0;
            end else if (acc) begin
                if (m_bc < CNT_MAX) m_bc++;
                if (t && m_tc < CNT_MAX) m_tc++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_in_ready", 64'(in_ready), 64'(en && !flush && (!m_valid || out_ready)));
            chk("m_out_valid", 64'(out_valid), 64'(m_valid));
            chk("m_taken", 64'(taken), 64'(m_taken));
            chk("m_zero", 64'(zero), 64'(m_zero));
            chk("m_branch_count", 64'(branch_count), 64'(m_bc));
            chk("m_taken_count", 64'(taken_count), 64'(m_tc));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        int          vc;
        bit          vt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1; en = 1; in_valid = 0; flush = 0; clear_stats = 0; out_ready = 0;
        a = '0; b = '0; cond = '0;
        cyc(); cyc();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_taken", 64'(taken), 0);
        chk("rst_counts", 64'({branch_count, taken_count}), 0);
        rst = 0;

        a = 5; b = 5; cond = COND_EQ; in_valid = 1; out_ready = 1;
        #1 chk("eq_in_ready", 64'(in_ready), 1);
        cyc();
        chk("eq_out_valid", 64'(out_valid), 1);
        chk("eq_taken", 64'(taken), 1);
        chk("eq_zero", 64'(zero), 1);
        chk("eq_bc", 64'(branch_count), 1);
        chk("eq_tc", 64'(taken_count), 1);

        in_valid = 0; clear_stats = 1;
        cyc();
        clear_stats = 0;
        chk("clr_bc", 64'(branch_count), 0);

        a = 32'hFFFF_FFFF; b = 1; cond = COND_LT; in_valid = 1;
        cyc();
        chk("lt_taken", 64'(taken), 1);
        chk("lt_valid", 64'(out_valid), 1);
        cond = COND_LTU;
        cyc();
        chk("ltu_taken", 64'(taken), 0);
        chk("ltu_valid", 64'(out_valid), 1);
        chk("ltu_bc", 64'(branch_count), 2);
        chk("ltu_tc", 64'(taken_count), 1);

        in_valid = 0; out_ready = 0;
        cyc();
        a = 0; cond = COND_LEZ; in_valid = 1;
        #1 chk("hold_in_ready", 64'(in_ready), 0);
        cyc(); cyc();
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_taken", 64'(taken), 0);
        chk("hold_bc", 64'(branch_count), 2);
        out_ready = 1;
        #1 chk("release_in_ready", 64'(in_ready), 1);
        cyc();
        chk("lez_taken", 64'(taken), 1);
        chk("lez_zero", 64'(zero), 0);
        chk("lez_bc", 64'(branch_count), 3);

        a = 5; b = 5; cond = COND_EQ; flush = 1;
        #1 chk("flush_in_ready", 64'(in_ready), 0);
        cyc();
        flush = 0; in_valid = 0;
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_bc", 64'(branch_count), 3);
        chk("flush_taken_kept", 64'(taken), 1);

        en = 0; in_valid = 1;
        #1 chk("en_in_ready", 64'(in_ready), 0);
        cyc();
        chk("en_valid", 64'(out_valid), 0);
        en = 1; in_valid = 0;

        vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 6, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 7, 1'b0});
        vecs.push_back('{32'h0000_0001, 32'h8000_0000, 3, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 3, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 4, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 5, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h1234_5678, 5, 1'b1});
        vecs.push_back('{32'h0000_0005, 32'h0000_0006, 1, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0000, 2, 1'b0});
        vecs.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFFF, 6, 1'b1});
        foreach (vecs[i]) begin
            a = vecs[i].va; b = vecs[i].vb; cond = 3'(vecs[i].vc); in_valid = 1;
            chk("vec_model_pin", 64'(ref_taken(vecs[i].va, vecs[i].vb, vecs[i].vc)), 64'(vecs[i].vt));
            cyc();
            chk("vec_taken", 64'(taken), 64'(vecs[i].vt));
        end

        for (int i = 0; i < 20; i++) begin
            a = 32'(i); b = 32'(i); cond = COND_EQ; in_valid = 1;
            cyc();
        end
        chk("sat_bc", 64'(branch_count), 15);
        chk("sat_tc", 64'(taken_count), 15);
        clear_stats = 1;
        cyc();
        clear_stats = 0;
        chk("clracc_bc", 64'(branch_count), 0);
        chk("clracc_tc", 64'(taken_count), 0);
        chk("clracc_valid", 64'(out_valid), 1);

        a = 3; b = 7; cond = COND_LTU; in_valid = 1; rst = 1;
        #1 chk("rst_in_ready", 64'(in_ready), 1);
        cyc();
        chk("midrst_valid", 64'(out_valid), 0);
        chk("midrst_taken", 64'(taken), 0);
        chk("midrst_counts", 64'({branch_count, taken_count}), 0);
        rst = 0; in_valid = 0;
        cyc();
        chk("midrst_lost", 64'(out_valid), 0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
